// File: rtl/acc_pkg.sv
// Shared types and widths for the accumulator write-back controller.
package acc_pkg;

    localparam int unsigned ACC_DATA_W = 8;
    localparam int unsigned ACC_ADDR_W = 2;
    localparam int unsigned NUM_ACC    = 2 ** ACC_ADDR_W;

    typedef struct packed {
        logic [ACC_ADDR_W-1:0] adr;
        logic [ACC_DATA_W-1:0] data;
    } acc_wr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        INIT  = 2'd2
    } wb_state_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/acc_wr_fifo.sv
// Small synchronous FIFO of accumulator writes with per-entry taps for the busy scoreboard.
module acc_wr_fifo
    import acc_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  acc_wr_t                       push_data,
    input  logic                          pop,
    output acc_wr_t                       head_c,
    output logic [CNT_W-1:0]              count,
    output logic                          full_c,
    output logic                          empty_c,
    output logic [DEPTH-1:0]              ent_valid_c,
    output logic [DEPTH-1:0][ACC_ADDR_W-1:0] ent_adr_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    acc_wr_t          mem_q [DEPTH];
    acc_wr_t          mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign count   = count_q;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push_ok = push && !full_c;
    assign pop_ok  = pop && !empty_c;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Slot i is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off         = '0;
        ent_valid_c = '0;
        ent_adr_c   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - rd_ptr_q;
            ent_valid_c[i] = (CNT_W'(off) < count_q);
            ent_adr_c[i]   = mem_q[i].adr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/acc_writeback_ctrl.sv
// Write-side controller for the accumulator file: two buffered sources, round-robin
// arbitration onto one registered write port, drain-then-clear sequence and busy scoreboard.
module acc_writeback_ctrl
    import acc_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 2,
    localparam int unsigned DATA_W     = ACC_DATA_W,
    localparam int unsigned ADDR_W     = ACC_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [ADDR_W-1:0]  alu_adr,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [ADDR_W-1:0]  mem_adr,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               init_req,
    output logic               init_busy,
    output logic               AcWen,
    output logic [ADDR_W-1:0]  WrAdr,
    output logic [DATA_W-1:0]  WrData,
    output logic [NUM_ACC-1:0] busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CLR_W = ADDR_W + 1;

    wb_state_e         state_q, state_d;
    wb_src_e           rr_q, rr_d;
    logic [CLR_W-1:0]  clr_q, clr_d;
    logic              acwen_q, acwen_d;
    logic [ADDR_W-1:0] wradr_q, wradr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;

    logic              pop_alu, pop_mem;
    acc_wr_t           alu_head, mem_head;
    logic [CNT_W-1:0]  alu_count, mem_count;
    logic              alu_full, mem_full;
    logic              alu_empty, mem_empty;
    logic [FIFO_DEPTH-1:0]             alu_ent_valid, mem_ent_valid;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] alu_ent_adr, mem_ent_adr;

    assign alu_ready = (state_q == RUN) && !alu_full;
    assign mem_ready = (state_q == RUN) && !mem_full;
    assign init_busy = (state_q != RUN);

    assign AcWen  = acwen_q;
    assign WrAdr  = wradr_q;
    assign WrData = wrdata_q;

    acc_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_valid && alu_ready),
        .push_data   ({alu_adr, alu_data}),
        .pop         (pop_alu),
        .head_c      (alu_head),
        .count       (alu_count),
        .full_c      (alu_full),
        .empty_c     (alu_empty),
        .ent_valid_c (alu_ent_valid),
        .ent_adr_c   (alu_ent_adr)
    );

    acc_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (mem_valid && mem_ready),
        .push_data   ({mem_adr, mem_data}),
        .pop         (pop_mem),
        .head_c      (mem_head),
        .count       (mem_count),
        .full_c      (mem_full),
        .empty_c     (mem_empty),
        .ent_valid_c (mem_ent_valid),
        .ent_adr_c   (mem_ent_adr)
    );

    // Next state, arbitration and output-register load.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        clr_d    = clr_q;
        acwen_d  = 1'b0;
        wradr_d  = wradr_q;
        wrdata_d = wrdata_q;
        pop_alu  = 1'b0;
        pop_mem  = 1'b0;

        unique case (state_q)
            RUN, DRAIN: begin
                if (!alu_empty && !mem_empty) begin
                    if (rr_q == SRC_MEM) begin
                        pop_mem = 1'b1;
                    end else begin
                        pop_alu = 1'b1;
                    end
                    rr_d = (rr_q == SRC_MEM) ? SRC_ALU : SRC_MEM;
                end else if (!alu_empty) begin
                    pop_alu = 1'b1;
                end else if (!mem_empty) begin
                    pop_mem = 1'b1;
                end

                if (pop_alu) begin
                    acwen_d  = 1'b1;
                    wradr_d  = alu_head.adr;
                    wrdata_d = alu_head.data;
                end else if (pop_mem) begin
                    acwen_d  = 1'b1;
                    wradr_d  = mem_head.adr;
                    wrdata_d = mem_head.data;
                end

                if (state_q == RUN && init_req) begin
                    state_d = DRAIN;
                end else if (state_q == DRAIN && alu_count == '0 && mem_count == '0) begin
                    state_d = INIT;
                    clr_d   = '0;
                end
            end
            INIT: begin
                // One extra cycle after the last clear keeps init_busy up while it is written.
                if (clr_q < CLR_W'(NUM_ACC)) begin
                    acwen_d  = 1'b1;
                    wradr_d  = ADDR_W'(clr_q);
                    wrdata_d = '0;
                    clr_d    = clr_q + CLR_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Busy scoreboard from buffered entries and the in-flight write.
    always_comb begin
        busy = '0;
        if (state_q == INIT) begin
            busy = '1;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (alu_ent_valid[i]) begin
                    busy[alu_ent_adr[i]] = 1'b1;
                end
                if (mem_ent_valid[i]) begin
                    busy[mem_ent_adr[i]] = 1'b1;
                end
            end
            if (acwen_q) begin
                busy[wradr_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            rr_q     <= SRC_MEM;
            clr_q    <= '0;
            acwen_q  <= 1'b0;
            wradr_q  <= '0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            clr_q    <= clr_d;
            acwen_q  <= acwen_d;
            wradr_q  <= wradr_d;
            wrdata_q <= wrdata_d;
        end
    end

endmodule

// File: tb/tb_acc_writeback_ctrl.sv
// Bench for acc_writeback_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_acc_writeback_ctrl;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0] adr;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alu_valid = 1'b0;
    logic       alu_ready;
    logic [1:0] alu_adr = '0;
    logic [7:0] alu_data = '0;
    logic       mem_valid = 1'b0;
    logic       mem_ready;
    logic [1:0] mem_adr = '0;
    logic [7:0] mem_data = '0;
    logic       init_req = 1'b0;
    logic       init_busy;
    logic       AcWen;
    logic [1:0] WrAdr;
    logic [7:0] WrData;
    logic [3:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    acc_writeback_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_adr   (alu_adr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_adr   (mem_adr),
        .mem_data  (mem_data),
        .init_req  (init_req),
        .init_busy (init_busy),
        .AcWen     (AcWen),
        .WrAdr     (WrAdr),
        .WrData    (WrData),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=normal, 1=flushing, 2=clearing.
    int         m_mode   = 0;
    logic       m_rr_mem = 1'b1;
    int         m_cnt    = 0;
    logic       m_wen    = 1'b0;
    logic [1:0] m_adr    = '0;
    logic [7:0] m_data   = '0;
    ent_t       qa[$];
    ent_t       qm[$];

    function automatic logic [3:0] model_busy();
        logic [3:0] b;
        b = '0;
        if (m_mode == 2) return 4'hF;
        foreach (qa[i]) b[qa[i].adr] = 1'b1;
        foreach (qm[i]) b[qm[i].adr] = 1'b1;
        if (m_wen) b[m_adr] = 1'b1;
        return b;
    endfunction

    initial begin : model
        logic acc_a, acc_m, ne_a, ne_m, take_a, take_m;
        int   nmode;
        ent_t e;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                qa.delete();
                qm.delete();
                m_mode   = 0;
                m_rr_mem = 1'b1;
                m_cnt    = 0;
                m_wen    = 1'b0;
                m_adr    = '0;
                m_data   = '0;
            end else begin
                acc_a = alu_valid && (m_mode == 0) && (qa.size() < DEPTH);
                acc_m = mem_valid && (m_mode == 0) && (qm.size() < DEPTH);
                ne_a  = (qa.size() > 0);
                ne_m  = (qm.size() > 0);
                nmode = m_mode;
                m_wen = 1'b0;
                if (m_mode == 2) begin
                    if (m_cnt < 4) begin
                        m_wen  = 1'b1;
                        m_adr  = 2'(m_cnt);
                        m_data = 8'h00;
                        m_cnt++;
                    end else begin
                        nmode = 0;
                    end
                end else begin
                    take_a = ne_a && (!ne_m || !m_rr_mem);
                    take_m = ne_m && !take_a;
                    if (ne_a && ne_m) m_rr_mem = !m_rr_mem;
                    if (take_a) begin
                        e = qa.pop_front();
                        m_wen = 1'b1; m_adr = e.adr; m_data = e.data;
                    end else if (take_m) begin
                        e = qm.pop_front();
                        m_wen = 1'b1; m_adr = e.adr; m_data = e.data;
                    end
                    if (m_mode == 0 && init_req) begin
                        nmode = 1;
                    end else if (m_mode == 1 && !ne_a && !ne_m) begin
                        nmode = 2;
                        m_cnt = 0;
                    end
                end
                if (acc_a) qa.push_back({alu_adr, alu_data});
                if (acc_m) qm.push_back({mem_adr, mem_data});
                m_mode = nmode;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            chk("cyc_alu_ready", 32'(alu_ready), 32'(m_mode == 0 && qa.size() < DEPTH));
            chk("cyc_mem_ready", 32'(mem_ready), 32'(m_mode == 0 && qm.size() < DEPTH));
            chk("cyc_init_busy", 32'(init_busy), 32'(m_mode != 0));
            chk("cyc_AcWen", 32'(AcWen), 32'(m_wen));
            chk("cyc_WrAdr", 32'(WrAdr), 32'(m_adr));
            chk("cyc_WrData", 32'(WrData), 32'(m_data));
            chk("cyc_busy", 32'(busy), 32'(model_busy()));
        end
    end

    logic [9:0] wlog[$];
    initial forever begin
        @(negedge clk);
        if (rst === 1'b1 && AcWen === 1'b1) wlog.push_back({WrAdr, WrData});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic       a_acc, m_acc, found, prev3, seen_a_low, seen_m_low;
        int         n_a, n_m, na_seen, nm_seen;
        logic [9:0] exp4 [6];
        logic [9:0] exp6 [3];
        logic [9:0] exp3 [4];

        // Reset and release
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rel_alu_ready", 32'(alu_ready), 32'd1);
        chk("rel_mem_ready", 32'(mem_ready), 32'd1);
        chk("rel_init_busy", 32'(init_busy), 32'd0);
        chk("rel_AcWen", 32'(AcWen), 32'd0);

        // Reset asserted while a write is on the port
        tick();
        alu_valid = 1'b1; alu_adr = 2'd3; alu_data = 8'h77;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("t1_pre_AcWen", 32'(AcWen), 32'd1);
        chk("t1_pre_WrAdr", 32'(WrAdr), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_AcWen", 32'(AcWen), 32'd0);
        chk("t1_rst_WrAdr", 32'(WrAdr), 32'd0);
        chk("t1_rst_WrData", 32'(WrData), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_init_busy", 32'(init_busy), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t1_rel_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_rel_mem_ready", 32'(mem_ready), 32'd1);
        chk("t1_rel_init_busy", 32'(init_busy), 32'd0);

        // Single write latency and busy window
        tick();
        alu_valid = 1'b1; alu_adr = 2'd2; alu_data = 8'h5A;
        tick();
        alu_valid = 1'b0;
        chk("t2_k_busy", 32'(busy), 32'h4);
        chk("t2_k_AcWen", 32'(AcWen), 32'd0);
        tick();
        chk("t2_k1_AcWen", 32'(AcWen), 32'd1);
        chk("t2_k1_WrAdr", 32'(WrAdr), 32'd2);
        chk("t2_k1_WrData", 32'(WrData), 32'h5A);
        chk("t2_k1_busy", 32'(busy), 32'h4);
        tick();
        chk("t2_k2_AcWen", 32'(AcWen), 32'd0);
        chk("t2_k2_busy", 32'(busy), 32'd0);

        // Contention between both sources
        wlog.delete();
        n_a = 0; n_m = 0; seen_a_low = 1'b0; seen_m_low = 1'b0;
        mem_valid = 1'b1; mem_adr = 2'd1; mem_data = 8'h11;
        alu_valid = 1'b1; alu_adr = 2'd3; alu_data = 8'h22;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a_acc = alu_ready;
            m_acc = mem_ready;
            if (!alu_ready) seen_a_low = 1'b1;
            if (!mem_ready) seen_m_low = 1'b1;
            @(posedge clk);
            #1;
            if (a_acc) begin alu_data = alu_data + 8'd1; n_a++; end
            if (m_acc) begin mem_data = mem_data + 8'd1; n_m++; end
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (8) tick();
        exp3[0] = {2'd1, 8'h11};
        exp3[1] = {2'd3, 8'h22};
        exp3[2] = {2'd1, 8'h12};
        exp3[3] = {2'd3, 8'h23};
        chk("t3_total", 32'(wlog.size()), 32'(n_a + n_m));
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk($sformatf("t3_first%0d", i), 32'(wlog[i]), 32'(exp3[i]));
        na_seen = 0; nm_seen = 0;
        foreach (wlog[i]) begin
            if (wlog[i][9:8] == 2'd1) begin
                chk("t3_mem_order", 32'(wlog[i][7:0]), 32'(8'h11 + nm_seen));
                nm_seen++;
            end else begin
                chk("t3_alu_adr", 32'(wlog[i][9:8]), 32'd3);
                chk("t3_alu_order", 32'(wlog[i][7:0]), 32'(8'h22 + na_seen));
                na_seen++;
            end
        end
        chk("t3_mem_count", 32'(nm_seen), 32'(n_m));
        chk("t3_alu_count", 32'(na_seen), 32'(n_a));
        chk("t3_alu_backpressure", 32'(seen_a_low), 32'd1);
        chk("t3_mem_backpressure", 32'(seen_m_low), 32'd1);

        // Init with pending alu writes
        wlog.delete();
        tick();
        alu_valid = 1'b1; alu_adr = 2'd0; alu_data = 8'hA1;
        tick();
        alu_adr = 2'd1; alu_data = 8'hA2; init_req = 1'b1;
        tick();
        alu_valid = 1'b0; init_req = 1'b0;
        chk("t4_alu_ready", 32'(alu_ready), 32'd0);
        chk("t4_mem_ready", 32'(mem_ready), 32'd0);
        chk("t4_init_busy", 32'(init_busy), 32'd1);
        found = 1'b0; prev3 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (init_busy === 1'b0) begin found = 1'b1; break; end
            if (AcWen === 1'b1 && WrAdr == 2'd0 && WrData == 8'h00)
                chk("t4_busy_all", 32'(busy), 32'hF);
            prev3 = (AcWen === 1'b1 && WrAdr == 2'd3 && WrData == 8'h00);
        end
        chk("t4_done", 32'(found), 32'd1);
        chk("t4_fall_after_adr3", 32'(prev3), 32'd1);
        exp4[0] = {2'd0, 8'hA1};
        exp4[1] = {2'd1, 8'hA2};
        exp4[2] = {2'd0, 8'h00};
        exp4[3] = {2'd1, 8'h00};
        exp4[4] = {2'd2, 8'h00};
        exp4[5] = {2'd3, 8'h00};
        chk("t4_count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++)
            chk($sformatf("t4_wr%0d", i), 32'(wlog[i]), 32'(exp4[i]));

        // Reset during the clear sequence
        tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (AcWen === 1'b1 && init_busy === 1'b1 && WrAdr == 2'd0 && WrData == 8'h00) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reached_clear", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_AcWen", 32'(AcWen), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_rel_init_busy", 32'(init_busy), 32'd0);
        chk("t5_rel_busy", 32'(busy), 32'd0);
        chk("t5_rel_alu_ready", 32'(alu_ready), 32'd1);
        wlog.delete();
        repeat (6) tick();
        chk("t5_no_clear_writes", 32'(wlog.size()), 32'd0);

        // Push and pop in the same cycle at count 1
        wlog.delete();
        tick();
        alu_valid = 1'b1; alu_adr = 2'd0; alu_data = 8'hB1;
        tick();
        alu_adr = 2'd1; alu_data = 8'hB2;
        tick();
        chk("t6_ready_a", 32'(alu_ready), 32'd1);
        chk("t6_busy_a", 32'(busy), 32'h3);
        alu_adr = 2'd2; alu_data = 8'hB3;
        tick();
        chk("t6_ready_b", 32'(alu_ready), 32'd1);
        chk("t6_busy_b", 32'(busy), 32'h6);
        alu_valid = 1'b0;
        repeat (4) tick();
        exp6[0] = {2'd0, 8'hB1};
        exp6[1] = {2'd1, 8'hB2};
        exp6[2] = {2'd2, 8'hB3};
        chk("t6_count", 32'(wlog.size()), 32'd3);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            chk($sformatf("t6_wr%0d", i), 32'(wlog[i]), 32'(exp6[i]));

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
